// File: rtl/fft8_frame_controller_pkg.sv
// Shared types and sizes for the 8-point FFT frame controller.
// Holds the controller state enum, half-precision and fixed-point types.
package fft8_frame_controller_pkg;

   localparam int HALF_W = 16;
   localparam int POINTS = 8;
   localparam int IDX_W  = 3;

   // Internal fixed point of the core: 24 integer bits, 24 fraction bits.
   // That holds any finite half value and the sum of eight of them exactly.
   localparam int FIX_W  = 48;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_SETTLE,
      ST_CAPTURE,
      ST_DRAIN
   } state_t;

   typedef logic [HALF_W-1:0]        half_t;
   typedef logic signed [FIX_W-1:0]  fix_t;

   typedef struct packed {
      fix_t re;
      fix_t im;
   } cplx_t;

   // Exponent all ones: infinity or NaN.
   function automatic logic half_special(half_t h);
      return &h[14:10];
   endfunction

endpackage

// File: rtl/fft8_frame_controller_core.sv
// fft_8point: combinational 8-point DFT/IDFT on half-precision samples.
// Ports: x_real/x_imag samples, inverse (IDFT with 1/8 scaling),
// y_real/y_imag bins, invalid_input (some sample is Inf or NaN).
module fft_8point
   import fft8_frame_controller_pkg::*;
(
   input  logic [POINTS-1:0][HALF_W-1:0] x_real,
   input  logic [POINTS-1:0][HALF_W-1:0] x_imag,
   input  logic                          inverse,
   output logic [POINTS-1:0][HALF_W-1:0] y_real,
   output logic [POINTS-1:0][HALF_W-1:0] y_imag,
   output logic                          invalid_input
);

   // cos(pi/4) in Q16
   localparam logic signed [17:0] COS45 = 18'sd46341;

   fix_t        xr [POINTS];
   fix_t        xi [POINTS];
   fix_t        acc_re;
   fix_t        acc_im;
   cplx_t       cin;
   cplx_t       term;
   logic [2:0]  idx;

   // Inf/NaN contribute zero; the invalid flag reports them.
   function automatic fix_t to_fix(half_t h);
      logic [FIX_W-1:0] mag;
      if (h[14:10] == 5'd0)
         mag = FIX_W'(h[9:0]);
      else if (half_special(h))
         mag = '0;
      else
         mag = FIX_W'({1'b1, h[9:0]}) << (h[14:10] - 5'd1);
      return h[15] ? -fix_t'(mag) : fix_t'(mag);
   endfunction

   // Magnitude is truncated; overflow saturates to infinity.
   function automatic half_t to_half(fix_t v);
      logic [FIX_W-1:0] mag;
      logic [FIX_W-1:0] norm;
      logic [5:0]       p;
      mag = v[FIX_W-1] ? FIX_W'(-v) : FIX_W'(v);
      p = '0;
      for (int b = 0; b < FIX_W; b++)
         if (mag[b]) p = 6'(b);
      if (mag == '0)
         return '0;
      if (p < 6'd10)
         return {v[FIX_W-1], 5'd0, mag[9:0]};
      if (p >= 6'd40)
         return {v[FIX_W-1], 5'h1f, 10'd0};
      norm = mag << (6'd47 - p);
      return {v[FIX_W-1], 5'(p - 6'd9), 10'(norm >> 37)};
   endfunction

   function automatic fix_t mul_c(logic signed [FIX_W:0] v);
      logic signed [FIX_W+18:0] prod;
      prod = v * COS45;
      return fix_t'(prod >>> 16);
   endfunction

   // Multiply by W^idx, W = exp(-j*pi/4).
   function automatic cplx_t twiddle(cplx_t x, logic [2:0] k);
      logic signed [FIX_W:0] sum;
      logic signed [FIX_W:0] dif;
      cplx_t                 y;
      sum = $signed({x.re[FIX_W-1], x.re}) + $signed({x.im[FIX_W-1], x.im});
      dif = $signed({x.im[FIX_W-1], x.im}) - $signed({x.re[FIX_W-1], x.re});
      unique case (k)
         3'd0: begin y.re = x.re;         y.im = x.im;         end
         3'd1: begin y.re = mul_c(sum);   y.im = mul_c(dif);   end
         3'd2: begin y.re = x.im;         y.im = -x.re;        end
         3'd3: begin y.re = mul_c(dif);   y.im = -mul_c(sum);  end
         3'd4: begin y.re = -x.re;        y.im = -x.im;        end
         3'd5: begin y.re = -mul_c(sum);  y.im = -mul_c(dif);  end
         3'd6: begin y.re = -x.im;        y.im = x.re;         end
         default: begin y.re = -mul_c(dif); y.im = mul_c(sum); end
      endcase
      return y;
   endfunction

   always_comb begin
      invalid_input = 1'b0;
      y_real        = '0;
      y_imag        = '0;
      xr            = '{default: '0};
      xi            = '{default: '0};
      acc_re        = '0;
      acc_im        = '0;
      cin           = '0;
      term          = '0;
      idx           = '0;
      for (int n = 0; n < POINTS; n++) begin
         xr[n] = to_fix(x_real[n]);
         xi[n] = to_fix(x_imag[n]);
         if (half_special(x_real[n]) || half_special(x_imag[n]))
            invalid_input = 1'b1;
      end
      for (int k = 0; k < POINTS; k++) begin
         acc_re = '0;
         acc_im = '0;
         for (int n = 0; n < POINTS; n++) begin
            idx = 3'(n * k);
            // Inverse uses the conjugate twiddle W^-nk.
            if (inverse) idx = -idx;
            cin.re = xr[n];
            cin.im = xi[n];
            term   = twiddle(cin, idx);
            acc_re = acc_re + term.re;
            acc_im = acc_im + term.im;
         end
         if (inverse) begin
            acc_re = acc_re >>> 3;
            acc_im = acc_im >>> 3;
         end
         y_real[k] = to_half(acc_re);
         y_imag[k] = to_half(acc_im);
      end
   end

endmodule

// File: rtl/fft8_frame_controller.sv
// Frame controller around fft_8point: loads 8 samples, lets the core settle,
// captures all bins, then drains them one per handshake.
// Ports: clk, rst (async high); in_valid/in_ready/in_real/in_imag/in_mode
// sample stream; flush abort; out_valid/out_ready/out_real/out_imag/
// out_index/out_last/out_invalid result stream; busy status.
module fft8_frame_controller
   import fft8_frame_controller_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_real,
   input  logic [15:0] in_imag,
   input  logic        in_mode,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_real,
   output logic [15:0] out_imag,
   output logic [2:0]  out_index,
   output logic        out_last,
   output logic        out_invalid,
   output logic        busy
);

   state_t                        state;
   logic [IDX_W-1:0]              cnt;
   logic [IDX_W-1:0]              cnt_nxt;
   logic [3:0]                    timer;
   logic                          frame_mode;
   logic [POINTS-1:0][HALF_W-1:0] smp_real;
   logic [POINTS-1:0][HALF_W-1:0] smp_imag;
   logic [POINTS-1:0][HALF_W-1:0] core_real;
   logic [POINTS-1:0][HALF_W-1:0] core_imag;
   logic [POINTS-1:0][HALF_W-1:0] res_real;
   logic [POINTS-1:0][HALF_W-1:0] res_imag;
   logic                          core_invalid;
   logic                          res_invalid;
   logic                          in_hs;
   logic                          out_hs;

   assign in_hs   = in_valid & in_ready;
   assign out_hs  = out_valid & out_ready;
   assign cnt_nxt = cnt + 3'd1;

   // Sample buffer: only written in LOAD, so it is stable through
   // SETTLE and CAPTURE.
   always_ff @(posedge clk) begin
      if (in_hs && !flush) begin
         smp_real[cnt] <= in_real;
         smp_imag[cnt] <= in_imag;
      end
   end

   always_ff @(posedge clk) begin
      if (state == ST_CAPTURE && !flush) begin
         res_real    <= core_real;
         res_imag    <= core_imag;
         res_invalid <= core_invalid;
      end
   end

   fft_8point u_core (
      .x_real        (smp_real),
      .x_imag        (smp_imag),
      .inverse       (frame_mode),
      .y_real        (core_real),
      .y_imag        (core_imag),
      .invalid_input (core_invalid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_LOAD;
         cnt         <= '0;
         timer       <= '0;
         frame_mode  <= 1'b0;
         in_ready    <= 1'b0;
         out_valid   <= 1'b0;
         out_real    <= '0;
         out_imag    <= '0;
         out_index   <= '0;
         out_last    <= 1'b0;
         out_invalid <= 1'b0;
         busy        <= 1'b0;
      end else if (flush) begin
         state     <= ST_LOAD;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            ST_LOAD: begin
               in_ready <= 1'b1;
               if (in_hs) begin
                  busy <= 1'b1;
                  if (cnt == 3'd0)
                     frame_mode <= in_mode;
                  if (cnt == 3'd7) begin
                     state    <= ST_SETTLE;
                     cnt      <= '0;
                     timer    <= 4'(SETTLE_CYCLES - 1);
                     in_ready <= 1'b0;
                  end else begin
                     cnt <= cnt_nxt;
                  end
               end
            end
            ST_SETTLE: begin
               if (timer == 4'd0)
                  state <= ST_CAPTURE;
               else
                  timer <= timer - 4'd1;
            end
            ST_CAPTURE: begin
               // Bin 0 goes straight to the output registers.
               state       <= ST_DRAIN;
               out_valid   <= 1'b1;
               out_real    <= core_real[0];
               out_imag    <= core_imag[0];
               out_index   <= '0;
               out_last    <= 1'b0;
               out_invalid <= core_invalid;
            end
            ST_DRAIN: begin
               if (out_hs) begin
                  if (cnt == 3'd7) begin
                     state     <= ST_LOAD;
                     cnt       <= '0;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     in_ready  <= 1'b1;
                     busy      <= 1'b0;
                  end else begin
                     cnt         <= cnt_nxt;
                     out_real    <= res_real[cnt_nxt];
                     out_imag    <= res_imag[cnt_nxt];
                     out_index   <= cnt_nxt;
                     out_last    <= (cnt_nxt == 3'd7);
                     out_invalid <= res_invalid;
                  end
               end
            end
            default: state <= ST_LOAD;
         endcase
      end
   end

endmodule
